// File: rtl/ql_membank_cfg_loader.sv
// Memory-bank configuration loader: assembles bitstream words into BL rows
// and strobes one word line per row with fixed setup/pulse/hold timing.
module ql_membank_cfg_loader #(
  parameter int NUM_BL    = 514,
  parameter int NUM_WL    = 407,
  parameter int DATA_W    = 32,
  parameter int SETUP_CYC = 2,
  parameter int WL_PULSE  = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              global_resetn,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              cfg_done,
  output logic              fabric_resetn
);

  localparam int WPR = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int TSP = (SETUP_CYC > WL_PULSE) ? SETUP_CYC : WL_PULSE;
  localparam int TMX = (TSP > HOLD_CYC) ? TSP : HOLD_CYC;
  localparam int TW  = $clog2(TMX + 1);

  localparam logic [WW-1:0] LAST_W    = WW'(WPR - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_WL - 1);
  localparam logic [TW-1:0] SETUP_END = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_END = TW'(WL_PULSE - 1);
  localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_CYC - 1);
  localparam logic [NUM_WL-1:0] WL_ONE = NUM_WL'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [WW-1:0]     wcnt;
  logic [RW-1:0]     row;
  logic [TW-1:0]     tcnt;
  logic [NUM_BL-1:0] stage;
  logic [NUM_BL-1:0] stage_nxt;
  logic              accept;

  assign s_ready = (state == LOAD);
  assign accept  = s_valid && s_ready;

  // Bits past NUM_BL in the last word simply have no destination.
  for (genvar j = 0; j < NUM_BL; j++) begin : g_stage
    assign stage_nxt[j] = (wcnt == WW'(j / DATA_W)) ?
                          s_data[j % DATA_W] : stage[j];
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state         <= IDLE;
      wcnt          <= '0;
      row           <= '0;
      tcnt          <= '0;
      stage         <= '0;
      bl            <= '0;
      wl            <= '0;
      busy          <= 1'b0;
      cfg_done      <= 1'b0;
      fabric_resetn <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= LOAD;
            wcnt          <= '0;
            row           <= '0;
            tcnt          <= '0;
            busy          <= 1'b1;
            cfg_done      <= 1'b0;
            fabric_resetn <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            stage <= stage_nxt;
            if (wcnt == LAST_W) begin
              bl    <= stage_nxt;
              wcnt  <= '0;
              tcnt  <= '0;
              state <= SETUP;
            end else begin
              wcnt <= wcnt + WW'(1);
            end
          end
        end
        SETUP: begin
          if (tcnt == SETUP_END) begin
            tcnt  <= '0;
            wl    <= WL_ONE << row;
            state <= PULSE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        PULSE: begin
          if (tcnt == PULSE_END) begin
            tcnt  <= '0;
            wl    <= '0;
            state <= HOLD;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        HOLD: begin
          if (tcnt == HOLD_END) begin
            tcnt <= '0;
            if (row == LAST_ROW) begin
              state         <= DONE;
              busy          <= 1'b0;
              cfg_done      <= 1'b1;
              fabric_resetn <= 1'b1;
            end else begin
              row   <= row + RW'(1);
              state <= LOAD;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ql_membank_cfg_loader.sv
// Bench for ql_membank_cfg_loader: directed row table, stall, start and
// reset corner cases, then random bitstreams against a row/timing model.
module tb_ql_membank_cfg_loader;

  localparam int NBL = 10;
  localparam int NWL = 3;
  localparam int DW  = 4;
  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 1;

  logic           clk;
  logic           global_resetn;
  logic           start;
  logic           s_valid;
  logic [DW-1:0]  s_data;
  logic           s_ready;
  logic [NBL-1:0] bl;
  logic [NWL-1:0] wl;
  logic           busy;
  logic           cfg_done;
  logic           fabric_resetn;

  int n_chk;
  int n_fail;

  ql_membank_cfg_loader #(
    .NUM_BL   (NBL),
    .NUM_WL   (NWL),
    .DATA_W   (DW),
    .SETUP_CYC(S),
    .WL_PULSE (P),
    .HOLD_CYC (H)
  ) dut (
    .clk          (clk),
    .global_resetn(global_resetn),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .bl           (bl),
    .wl           (wl),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .fabric_resetn(fabric_resetn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  w0;
    logic [DW-1:0]  w1;
    logic [DW-1:0]  w2;
    logic [NBL-1:0] exp;
    int             stall;
    bit             st_pulse;
  } vec_t;

  vec_t tbl [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Row image: word i occupies bits [i*DW +: DW]; anything past NBL is lost.
  function automatic logic [NBL-1:0] model_row(input logic [DW-1:0] w0,
                                               input logic [DW-1:0] w1,
                                               input logic [DW-1:0] w2);
    logic [63:0] acc;
    acc = 64'(w0) | (64'(w1) << DW) | (64'(w2) << (2 * DW));
    return acc[NBL-1:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bl"}, 32'(bl), 32'd0);
    chk({tag, "_wl"}, 32'(wl), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    chk({tag, "_fabric_resetn"}, 32'(fabric_resetn), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_s_ready", 32'(s_ready), 32'd1);
    chk("start_cfg_done", 32'(cfg_done), 32'd0);
    chk("start_fabric_resetn", 32'(fabric_resetn), 32'd0);
    chk("start_wl", 32'(wl), 32'd0);
  endtask

  task automatic run_row(input logic [DW-1:0] w0,
                         input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2,
                         input logic [NBL-1:0] exp,
                         input int row,
                         input bit last,
                         input int stall,
                         input bit st_pulse,
                         input bit rst_pulse);
    logic [DW-1:0]  w [3];
    logic [NBL-1:0] prev;
    int             n;
    int             exp_wl;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    n = 0;
    while (s_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(s_ready), 32'd1);
    prev = bl;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = w[i];
      tick();
      s_valid = 1'b0;
      s_data  = DW'($urandom);
      if (i < 2) begin
        chk("bl_stable", 32'(bl), 32'(prev));
        chk("load_ready", 32'(s_ready), 32'd1);
      end
      if (i == 1) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("stall_bl", 32'(bl), 32'(prev));
          chk("stall_ready", 32'(s_ready), 32'd1);
        end
      end
    end
    chk("bl_row", 32'(bl), 32'(exp));
    for (int k = 0; k <= S + P + H; k++) begin
      if (k > 0) begin
        s_valid = 1'($urandom);
        s_data  = DW'($urandom);
        start   = st_pulse && (k == S + 1);
        tick();
        start   = 1'b0;
      end
      exp_wl = (k >= S && k < S + P) ? (1 << row) : 0;
      chk("wl_timing", 32'(wl), 32'(exp_wl));
      chk("bl_hold", 32'(bl), 32'(exp));
      if (k == S + P + H) begin
        chk("end_s_ready", 32'(s_ready), last ? 32'd0 : 32'd1);
        chk("end_busy", 32'(busy), last ? 32'd0 : 32'd1);
        chk("end_cfg_done", 32'(cfg_done), last ? 32'd1 : 32'd0);
        chk("end_fabric_resetn", 32'(fabric_resetn), last ? 32'd1 : 32'd0);
      end else begin
        chk("row_s_ready", 32'(s_ready), 32'd0);
        chk("row_busy", 32'(busy), 32'd1);
      end
      if (rst_pulse && k == S + 1) begin
        s_valid = 1'b0;
        #2 global_resetn = 1'b0;
        #1 chk_reset_vals("async_rst");
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic run_random_cfg();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    for (int r = 0; r < NWL; r++) begin
      a = DW'($urandom);
      b = DW'($urandom);
      c = DW'($urandom);
      run_row(a, b, c, model_row(a, b, c), r, r == NWL - 1,
              int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    n_chk  = 0;
    n_fail = 0;
    tbl[0] = '{4'h5, 4'hA, 4'h3, 10'h3A5, 0, 1'b0};
    tbl[1] = '{4'hF, 4'hF, 4'hF, 10'h3FF, 7, 1'b1};
    tbl[2] = '{4'h0, 4'h0, 4'hC, 10'h000, 0, 1'b0};

    global_resetn = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #3 chk_reset_vals("reset");
    tick();
    tick();
    global_resetn = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;

    do_start();
    for (int i = 0; i < 3; i++)
      run_row(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].exp, i, i == 2,
              tbl[i].stall, tbl[i].st_pulse, 1'b0);

    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = DW'($urandom);
      tick();
      chk("done_s_ready", 32'(s_ready), 32'd0);
      chk("done_cfg_done", 32'(cfg_done), 32'd1);
      chk("done_bl", 32'(bl), 32'h000);
    end
    s_valid = 1'b0;

    do_start();
    a = DW'($urandom);
    b = DW'($urandom);
    c = DW'($urandom);
    run_row(a, b, c, model_row(a, b, c), 0, 1'b0, 0, 1'b0, 1'b0);
    a = DW'($urandom);
    b = DW'($urandom);
    c = DW'($urandom);
    run_row(a, b, c, model_row(a, b, c), 1, 1'b0, 0, 1'b0, 1'b1);

    tick();
    global_resetn = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    for (int cfg = 0; cfg < 3; cfg++) begin
      do_start();
      run_random_cfg();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ql_membank_cfg_loader.md
Name: ql_membank_cfg_loader

Overview:
Configuration loader directly upstream of fpga_top's memory-bank configuration ports. It accepts a bitstream as a valid/ready word stream and assembles one bit-line (BL) row at a time. For each row it pulses the matching word line (WL) with fixed setup, pulse and hold timing, driving the fabric's bl_config_region_0 and wl_config_region_0. After the last row it flags completion and releases the fabric's global_resetn.

Parameters:
NUM_BL, 514, bit lines per row; width of bl output.
NUM_WL, 407, word lines (rows); width of wl output.
DATA_W, 32, input word width.
SETUP_CYC, 2, cycles BL is stable with WL low before the pulse (>=1).
WL_PULSE, 4, cycles WL is held high (>=1).
HOLD_CYC, 2, cycles BL is stable with WL low after the pulse (>=1).
Derived: WPR = ceil(NUM_BL/DATA_W), words per row.

Ports:
clk  input  1  loader clock, rising edge.
global_resetn  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin configuration.
s_valid  input  1  input word valid.
s_data  input  DATA_W  bitstream word.
s_ready  output  1  loader accepts a word this cycle.
bl  output  NUM_BL  bit-line drive, connects to bl_config_region_0[0:NUM_BL-1].
wl  output  NUM_WL  word-line drive (one-hot or zero), connects to wl_config_region_0[0:NUM_WL-1].
busy  output  1  configuration in progress.
cfg_done  output  1  all rows written.
fabric_resetn  output  1  drives the fabric's global_resetn; low until configuration completes.

Behaviour:
- Reset (async assert, sync deassert by the user) puts every output low: bl=0, wl=0, s_ready=0, busy=0, cfg_done=0, fabric_resetn=0. State=IDLE, row=0, wcnt=0, staging buffer=0.
- States: IDLE, LOAD, SETUP, PULSE, HOLD, DONE.
- IDLE: start -> LOAD with row=0, wcnt=0, busy=1.
- LOAD: s_ready=1 and combinational from state only; it does not depend on s_valid.
  - A word is accepted when s_valid&&s_ready. On accept, s_data bit j goes to staging[wcnt*DATA_W+j].
  - Bits with index >= NUM_BL are discarded. The last word uses only its NUM_BL-(WPR-1)*DATA_W LSBs.
  - wcnt then increments.
  - On the edge accepting word WPR-1: bl<=assembled row (including that word), wcnt<=0, state -> SETUP.
  - bl changes only on this edge; it is otherwise stable.
- SETUP: s_ready=0, wl=0, for SETUP_CYC cycles, then PULSE.
- PULSE: wl[row]=1 and all other wl bits 0, for exactly WL_PULSE cycles, then HOLD. wl is registered and glitch-free.
- HOLD: wl=0 for HOLD_CYC cycles.
  - If row==NUM_WL-1 -> DONE.
  - Otherwise row<=row+1 -> LOAD.
- Per-row timing with E0 = last-word acceptance edge:
  - wl rises at E0+SETUP_CYC and falls at E0+SETUP_CYC+WL_PULSE.
  - s_ready reasserts at E0+SETUP_CYC+WL_PULSE+HOLD_CYC.
- DONE: busy=0, cfg_done=1, fabric_resetn=1 (registered, same edge as entry). bl holds its last row; wl=0.
- start handling:
  - start in LOAD..HOLD is ignored.
  - start in DONE clears cfg_done and fabric_resetn, then restarts at row 0 as from IDLE.
- s_valid is ignored outside LOAD; no word is consumed.
- A stalled stream (s_valid=0) in LOAD holds all state indefinitely; partial-row words are kept.
- Reset asserted mid-row (any state) immediately forces all outputs to reset values. This includes dropping wl mid-pulse. A partial row is discarded.
- Counters: wcnt width clog2(WPR), row width clog2(NUM_WL), timing counter width clog2(max(SETUP_CYC,WL_PULSE,HOLD_CYC)+1). None wraps in legal operation.

Test Plan:
- NUM_BL=10, NUM_WL=3, DATA_W=4, SETUP=2, PULSE=3, HOLD=1: start, then stream 9 words. Per row, bl takes its value on the third accept. Words 0x5,0xA,0x3 -> bl=10'b11_1010_0101 (bl[0]=1). Upper 2 bits of the third word are dropped.
- Same configuration, row timing: wl[0] rises exactly 2 cycles after the third accept and stays high 3 cycles; s_ready returns 1 cycle after wl falls. Rows 1 and 2 pulse wl[1] and wl[2] in order; wl is never multi-hot.
- Completion: after the row-2 HOLD, cfg_done=1, fabric_resetn=1 and busy=0 on the same edge. A further s_valid is not accepted (s_ready=0).
- Backpressure/stall: deassert s_valid for 7 cycles after word 1 of a row. State, wcnt and bl are unchanged; resuming with word 2 completes the row with correct data.
- Start while busy: pulse start during PULSE of row 1 -> no effect; row counter and timing unchanged. A start in DONE restarts at row 0 with cfg_done cleared.
- Async reset during PULSE of row 1: wl, bl, busy and fabric_resetn go 0 without waiting for a clock edge. After release and start, the loader begins at row 0 with wcnt=0.
